// File: rtl/ideal_icache_refill_ctrl_if.sv
// Handshake bundle between the refill controller and its environment:
// request/response, ideal-ICache lookup/refill, and memory line read.
interface ideal_icache_refill_ctrl_if;
    logic         req_valid;
    logic         req_ready;
    logic [63:0]  req_paddr;
    logic         lookup_valid;
    logic         lookup_port;
    logic [63:0]  lookup_paddr;
    logic         lookup_hit;
    logic [511:0] lookup_data;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [63:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [63:0]  mem_resp_data;
    logic         mem_resp_last;
    logic         refill_valid;
    logic [63:0]  refill_paddr;
    logic [511:0] refill_data;
    logic         resp_valid;
    logic         resp_ready;
    logic [511:0] resp_data;
    logic         resp_hit;
    logic         resp_err;

    modport master (
        input  req_valid, req_paddr, lookup_hit, lookup_data, mem_req_ready,
               mem_resp_valid, mem_resp_data, mem_resp_last, resp_ready,
        output req_ready, lookup_valid, lookup_port, lookup_paddr,
               mem_req_valid, mem_req_addr, refill_valid, refill_paddr,
               refill_data, resp_valid, resp_data, resp_hit, resp_err
    );

    modport slave (
        output req_valid, req_paddr, lookup_hit, lookup_data, mem_req_ready,
               mem_resp_valid, mem_resp_data, mem_resp_last, resp_ready,
        input  req_ready, lookup_valid, lookup_port, lookup_paddr,
               mem_req_valid, mem_req_addr, refill_valid, refill_paddr,
               refill_data, resp_valid, resp_data, resp_hit, resp_err
    );
endinterface

// File: rtl/ideal_icache_refill_ctrl.sv
// Ideal-ICache initiator: one line fetch at a time, lookup first, on miss read
// eight beats from memory, refill the model, then return the line.
//
// state    | meaning
// IDLE     | ready for a new fetch request
// LOOKUP   | single-cycle lookup strobe, hit sampled
// MEM_REQ  | line read request held until accepted
// MEM_RESP | collecting beats into the line register
// REFILL   | single-cycle refill strobe back to the model
// RESP     | line presented until consumer accepts
module ideal_icache_refill_ctrl #(
    parameter logic PORT  = 1'b0,
    parameter int   CNT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    ideal_icache_refill_ctrl_if.master bus,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MEM_REQ, MEM_RESP, REFILL, RESP
    } state_t;

    state_t             state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic [63:0]        addr_q, addr_d;
    logic [511:0]       line_q, line_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               hit_q, hit_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            line_q      <= '0;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            addr_q      <= addr_d;
            line_q      <= line_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            err_q       <= err_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        hit_d      = hit_q;
        err_d      = err_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_ready_q && bus.req_valid) begin
                    addr_d  = bus.req_paddr & ~64'h3F;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.lookup_hit) begin
                    line_d  = bus.lookup_data;
                    hit_d   = 1'b1;
                    state_d = RESP;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                end else begin
                    line_d  = '0;
                    hit_d   = 1'b0;
                    state_d = MEM_REQ;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                end
            end
            MEM_REQ: begin
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = MEM_RESP;
                end
            end
            MEM_RESP: begin
                if (bus.mem_resp_valid) begin
                    line_d[{cnt_q, 6'd0} +: 64] = bus.mem_resp_data;
                    cnt_d = cnt_q + 3'd1;
                    // a short or overlong line is returned flagged, never refilled
                    if (bus.mem_resp_last && cnt_q == 3'd7) begin
                        state_d = REFILL;
                    end else if (bus.mem_resp_last || cnt_q == 3'd7) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            REFILL: state_d = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.lookup_valid  = (state_q == LOOKUP);
    assign bus.lookup_port   = PORT;
    assign bus.lookup_paddr  = addr_q;
    assign bus.mem_req_valid = (state_q == MEM_REQ);
    assign bus.mem_req_addr  = addr_q;
    assign bus.refill_valid  = (state_q == REFILL);
    assign bus.refill_paddr  = addr_q;
    assign bus.refill_data   = line_q;
    assign bus.resp_valid    = (state_q == RESP);
    assign bus.resp_data     = line_q;
    assign bus.resp_hit      = hit_q;
    assign bus.resp_err      = err_q;
    assign hit_count         = hit_cnt_q;
    assign miss_count        = miss_cnt_q;

endmodule

// File: doc/ideal_icache_refill_ctrl.md
Name: ideal_icache_refill_ctrl

Overview:
- Initiator side of the ideal-ICache lookup/refill interface.
- Accepts one line-fetch request at a time and issues a single-cycle lookup (valid/port/paddr) to the ideal-ICache model.
- On a hit, it returns the 512-bit line.
- On a miss, it fetches 8×64-bit beats from memory, pulses a one-cycle refill (valid/paddr/data) back to the model, then returns the line.

Parameters:
- PORT, 0: constant driven on lookup_port (selects ideal-ICache port).
- CNT_W, 32: width of hit/miss statistics counters.

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  block can accept request
- req_paddr  in  64  fetch physical address (any byte offset)
- lookup_valid  out  1  lookup strobe to ideal ICache
- lookup_port  out  1  = PORT
- lookup_paddr  out  64  line-aligned address (paddr & ~63)
- lookup_hit  in  1  combinational hit, same cycle as lookup_valid
- lookup_data  in  512  hit line, beat k at [64k+63:64k]
- mem_req_valid  out  1  memory line-read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  64  line-aligned address
- mem_resp_valid  in  1  beat valid (no backpressure)
- mem_resp_data  in  64  beat data, ascending order
- mem_resp_last  in  1  final beat marker
- refill_valid  out  1  one-cycle refill strobe
- refill_paddr  out  64  line-aligned address
- refill_data  out  512  assembled line
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_data  out  512  line data
- resp_hit  out  1  1 = served by lookup, 0 = via memory
- resp_err  out  1  beat-count/last mismatch on this line
- hit_count  out  CNT_W  saturating hit count
- miss_count  out  CNT_W  saturating miss count

Behaviour:
- Reset: async on reset_n low, regardless of state.
  - All outputs 0, except lookup_port = PORT.
  - State IDLE; line/address/beat registers cleared; counters 0.
  - No refill pulse is emitted for an aborted transaction.
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_RESP, REFILL, RESP.
- IDLE:
  - req_ready = 1; it is 0 in every other state.
  - On req_valid: latch line address, go LOOKUP.
- LOOKUP (exactly 1 cycle):
  - lookup_valid = 1; sample lookup_hit.
  - Hit: capture lookup_data, resp_hit = 1, increment hit_count, go RESP.
  - Miss: clear line register, increment miss_count, go MEM_REQ.
- MEM_REQ:
  - mem_req_valid held 1 with stable address until mem_req_ready.
  - On handshake: beat counter = 0, go MEM_RESP.
- MEM_RESP:
  - Each mem_resp_valid writes mem_resp_data into beat[cnt]; cnt increments (3-bit).
  - Line ends on the first of: (a) last with cnt = 7; (b) last with cnt < 7 (early); (c) beat cnt = 7 without last (late).
  - (a): go REFILL.
  - (b)/(c): resp_err = 1, unwritten beats stay 0, skip REFILL, go RESP.
  - Beats arriving outside MEM_RESP are ignored.
- REFILL (exactly 1 cycle):
  - refill_valid = 1 with refill_paddr/refill_data.
  - Go RESP, resp_hit = 0.
- RESP:
  - resp_valid = 1; resp_data/resp_hit/resp_err stable until resp_ready.
  - On handshake: return to IDLE and clear resp_err.
  - The next request is accepted no earlier than the following cycle.
- Latency, request handshake at cycle 0:
  - Hit: lookup_valid at cycle 1, resp_valid at cycle 2.
  - Miss: mem_req_valid from cycle 2; refill_valid the cycle after the last beat; resp_valid the cycle after refill.
- Counters saturate at all-ones and never wrap.
- refill_data/refill_paddr may hold stale values when refill_valid = 0.

Test Plan:
- Hit: req 0x8000_0123, lookup_hit = 1, data beat k = 0x1111_0000_0000_000k → lookup_paddr 0x8000_0100 at cycle 1; resp_valid cycle 2 with that data, resp_hit = 1; no mem_req or refill; hit_count = 1.
- Miss: req 0x8000_1040, lookup_hit = 0, 8 beats 0xA0..0xA7 with last on beat 7 → mem_req_addr 0x8000_1040; one refill_valid pulse with same data; resp_hit = 0, resp_err = 0; miss_count = 1.
- Backpressure: mem_req_ready low for 5 cycles and resp_ready low for 3 cycles → mem_req_valid, address, resp_valid and resp_data held stable; exactly one refill pulse.
- Early last: last on beat 3 (data 0xB0..0xB3) → no refill_valid; resp_err = 1; beats 4–7 = 0. Late case: 8 beats without last → resp_err = 1, no refill.
- Reset mid-MEM_RESP: assert reset_n = 0 after beat 2 → all outputs 0 immediately; no refill. After release, a fresh hit request completes normally with counters starting from 0.
- Saturation: force counters near max (CNT_W = 4), run 20 hits → hit_count stays at 15.
